// File: rtl/issue_scheduler.sv
// Dual-issue in-order instruction queue with RAW/WAW/structural/control pairing
// checks and a one-deep load-use tracker.
module issue_scheduler #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [1:0]                 fetch_valid,
  input  logic [31:0]                fetch_inst0,
  input  logic [31:0]                fetch_inst1,
  input  logic [31:0]                fetch_pc0,
  input  logic [31:0]                fetch_pc1,
  output logic                       fetch_ready,
  input  logic                       flush,
  output logic [1:0]                 issue_valid,
  output logic [31:0]                issue_inst0,
  output logic [31:0]                issue_inst1,
  output logic [31:0]                issue_pc0,
  output logic [31:0]                issue_pc1,
  input  logic                       issue_ready,
  output logic [$clog2(DEPTH):0]     queue_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Destination register, or x0 when the instruction writes nothing.
  function automatic logic [4:0] dest(input logic [6:0] op, input logic [4:0] rd);
    logic w;
    w = 1'b0;
    case (op)
      OP_R, OP_IMM, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: w = 1'b1;
      default: ;
    endcase
    return w ? rd : 5'd0;
  endfunction

  function automatic logic reads(input logic [6:0] op, input logic [4:0] rs1,
                                 input logic [4:0] rs2, input logic [4:0] r);
    logic u1, u2;
    u1 = 1'b0;
    u2 = 1'b0;
    case (op)
      OP_R, OP_STORE, OP_BRANCH: begin u1 = 1'b1; u2 = 1'b1; end
      OP_IMM, OP_LOAD, OP_JALR:  u1 = 1'b1;
      default: ;
    endcase
    return (r != 5'd0) && ((u1 && rs1 == r) || (u2 && rs2 == r));
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   pc_q   [DEPTH];
  logic [PW-1:0] head_q, tail_q;
  logic [CW-1:0] count_q;
  logic          ld_valid_q;
  logic [4:0]    ld_rd_q;

  logic [PW-1:0] head1, tail1;
  logic [6:0]    op0, op1;
  logic [4:0]    rd0, rd1, rs1_0, rs2_0, rs1_1, rs2_1, dst0, dst1;
  logic          v0, v1, pair_hz, ld_nv;
  logic [4:0]    ld_nrd;
  logic [CW-1:0] enq_n, deq_n;

  assign head1       = head_q + PW'(1);
  assign tail1       = tail_q + PW'(1);
  assign issue_inst0 = inst_q[head_q];
  assign issue_inst1 = inst_q[head1];
  assign issue_pc0   = pc_q[head_q];
  assign issue_pc1   = pc_q[head1];
  assign queue_count = count_q;
  assign fetch_ready = (CW'(DEPTH) - count_q) >= CW'(2);
  assign issue_valid = {v1, v0};

  assign op0   = issue_inst0[6:0];
  assign rd0   = issue_inst0[11:7];
  assign rs1_0 = issue_inst0[19:15];
  assign rs2_0 = issue_inst0[24:20];
  assign op1   = issue_inst1[6:0];
  assign rd1   = issue_inst1[11:7];
  assign rs1_1 = issue_inst1[19:15];
  assign rs2_1 = issue_inst1[24:20];
  assign dst0  = dest(op0, rd0);
  assign dst1  = dest(op1, rd1);

  // Issue eligibility of the head pair.
  always_comb begin
    v0      = 1'b0;
    v1      = 1'b0;
    pair_hz = 1'b0;
    v0 = (count_q >= CW'(1)) && !flush && !(ld_valid_q && reads(op0, rs1_0, rs2_0, ld_rd_q));
    pair_hz = reads(op1, rs1_1, rs2_1, dst0)
           || (dst0 != 5'd0 && dst0 == dst1)
           || (is_mem(op0) && is_mem(op1))
           || is_ctrl(op0)
           || (ld_valid_q && reads(op1, rs1_1, rs2_1, ld_rd_q));
    v1 = v0 && (count_q >= CW'(2)) && !pair_hz;
  end

  // Transfer counts and the youngest issued load for the tracker.
  always_comb begin
    enq_n  = '0;
    deq_n  = '0;
    ld_nv  = 1'b0;
    ld_nrd = ld_rd_q;
    if (fetch_ready && !flush) begin
      case (fetch_valid)
        2'b01:   enq_n = CW'(1);
        2'b11:   enq_n = CW'(2);
        default: enq_n = '0;
      endcase
    end
    if (issue_ready) deq_n = CW'(v0) + CW'(v1);
    if (v0 && op0 == OP_LOAD && rd0 != 5'd0) begin
      ld_nv  = 1'b1;
      ld_nrd = rd0;
    end
    if (v1 && op1 == OP_LOAD && rd1 != 5'd0) begin
      ld_nv  = 1'b1;
      ld_nrd = rd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ld_valid_q <= 1'b0;
      ld_rd_q    <= 5'd0;
    end else if (flush) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      ld_valid_q <= 1'b0;
    end else begin
      head_q  <= head_q + PW'(deq_n);
      tail_q  <= tail_q + PW'(enq_n);
      count_q <= count_q + enq_n - deq_n;
      if (issue_ready) begin
        ld_valid_q <= ld_nv;
        ld_rd_q    <= ld_nrd;
      end
    end
  end

  // Storage has no reset; occupancy alone defines what is live.
  always_ff @(posedge clk) begin
    if (rst_n && enq_n != '0) begin
      inst_q[tail_q] <= fetch_inst0;
      pc_q[tail_q]   <= fetch_pc0;
      if (enq_n == CW'(2)) begin
        inst_q[tail1] <= fetch_inst1;
        pc_q[tail1]   <= fetch_pc1;
      end
    end
  end

endmodule
